jtag_host_shifter: RTL and testbench

JTAG_HOST_SHIFTER -- requirements
Module: jtag_host_shifter

---
 rtl/jtag_host_pkg.sv | 16 +
 rtl/jtag_tck_div.sv | 38 +++
 rtl/jtag_host_shifter.sv | 198 +++++++++++++++++++
 tb/tb_jtag_host_shifter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_host_pkg.sv
// Shared types and defaults for the JTAG host shifter.
package jtag_host_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int unsigned MAX_LEN_DEFAULT = 32;
    localparam int unsigned LEN_W_DEFAULT   = $clog2(MAX_LEN_DEFAULT + 1);

    typedef logic [LEN_W_DEFAULT-1:0] len_t;

endpackage

// File: rtl/jtag_tck_div.sv
// Phase timer: pulses tick on the last system cycle of each TCK half-period.
module jtag_tck_div #(
    parameter int unsigned HalfPeriod = 6
) (
    input  logic clk_sys_i,
    input  logic rst_sys_ni,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int unsigned     CntW   = (HalfPeriod > 1) ? $clog2(HalfPeriod) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(HalfPeriod - 1);

    logic [CntW-1:0] cnt_r;
    logic            tick_s;

    // Phase end when the running count reaches HalfPeriod-1.
    always_comb begin
        tick_s = enable && (cnt_r == CntMax);
    end

    // Counter restarts on accept and reloads at every phase change.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            cnt_r <= {CntW{1'b0}};
        end else if (restart || tick_s) begin
            cnt_r <= {CntW{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_r + CntW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/jtag_host_shifter.sv
// JTAG host: shifts up to MaxLen TMS/TDI bits per command and returns captured TDO.
module jtag_host_shifter
    import jtag_host_pkg::*;
#(
    parameter int unsigned HalfPeriod = 6,
    parameter int unsigned MaxLen     = MAX_LEN_DEFAULT
) (
    input  logic                           clk_sys_i,
    input  logic                           rst_sys_ni,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [$clog2(MaxLen+1)-1:0]    cmd_len,
    input  logic [MaxLen-1:0]              cmd_tms,
    input  logic [MaxLen-1:0]              cmd_tdi,
    input  logic                           cmd_trst,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [MaxLen-1:0]              rsp_tdo,
    output logic                           tck_o,
    output logic                           tms_o,
    output logic                           td_o,
    output logic                           trst_no,
    input  logic                           td_i
);

    localparam int unsigned LenW = $clog2(MaxLen + 1);

    state_e            state_r;
    state_e            state_nxt_s;
    logic              accept_s;
    logic              enable_s;
    logic              tick_s;
    logic              last_bit_s;
    logic [LenW-1:0]   len_clamp_s;
    logic [LenW-1:0]   len_r;
    logic [LenW-1:0]   bit_cnt_r;
    logic [MaxLen-1:0] tms_sh_r;
    logic [MaxLen-1:0] tdi_sh_r;
    logic [MaxLen-1:0] rsp_tdo_r;
    logic              tck_r;
    logic              tms_r;
    logic              td_r;
    logic              trst_n_r;
    logic              cmd_ready_r;
    logic              rsp_valid_r;
    logic              tck_nxt_s;
    logic              cmd_ready_nxt_s;
    logic              rsp_valid_nxt_s;

    jtag_tck_div #(
        .HalfPeriod (HalfPeriod)
    ) u_tck_div (
        .clk_sys_i  (clk_sys_i),
        .rst_sys_ni (rst_sys_ni),
        .restart    (accept_s),
        .enable     (enable_s),
        .tick       (tick_s)
    );

    // Command acceptance, length clamp and phase status decode.
    always_comb begin
        accept_s   = cmd_valid && (state_r == ST_IDLE);
        enable_s   = (state_r == ST_LOW) || (state_r == ST_HIGH);
        last_bit_s = (bit_cnt_r == (len_r - LenW'(1)));
        if (cmd_len > LenW'(MaxLen)) begin
            len_clamp_s = LenW'(MaxLen);
        end else begin
            len_clamp_s = cmd_len;
        end
    end

    // State register.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a zero-length command skips straight to the response.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (len_clamp_s == {LenW{1'b0}}) begin
                        state_nxt_s = ST_RESP;
                    end else begin
                        state_nxt_s = ST_LOW;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (tick_s) begin
                    state_nxt_s = ST_HIGH;
                end else begin
                    state_nxt_s = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (tick_s) begin
                    state_nxt_s = last_bit_s ? ST_RESP : ST_LOW;
                end else begin
                    state_nxt_s = ST_HIGH;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the flops track the state exactly.
    always_comb begin
        tck_nxt_s       = (state_nxt_s == ST_HIGH);
        cmd_ready_nxt_s = (state_nxt_s == ST_IDLE);
        rsp_valid_nxt_s = (state_nxt_s == ST_RESP);
    end

    // Shift datapath: TDO is captured on the same edge that drops TCK.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            tck_r       <= 1'b0;
            tms_r       <= 1'b1;
            td_r        <= 1'b0;
            trst_n_r    <= 1'b1;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_tdo_r   <= {MaxLen{1'b0}};
            tms_sh_r    <= {MaxLen{1'b0}};
            tdi_sh_r    <= {MaxLen{1'b0}};
            len_r       <= {LenW{1'b0}};
            bit_cnt_r   <= {LenW{1'b0}};
        end else begin
            tck_r       <= tck_nxt_s;
            cmd_ready_r <= cmd_ready_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            if (accept_s) begin
                tms_sh_r  <= {1'b0, cmd_tms[MaxLen-1:1]};
                tdi_sh_r  <= {1'b0, cmd_tdi[MaxLen-1:1]};
                len_r     <= len_clamp_s;
                bit_cnt_r <= {LenW{1'b0}};
                rsp_tdo_r <= {MaxLen{1'b0}};
                if (len_clamp_s != {LenW{1'b0}}) begin
                    tms_r    <= cmd_tms[0];
                    td_r     <= cmd_tdi[0];
                    trst_n_r <= ~cmd_trst;
                end else begin
                    tms_r    <= tms_r;
                    td_r     <= td_r;
                    trst_n_r <= trst_n_r;
                end
            end else if ((state_r == ST_HIGH) && tick_s) begin
                rsp_tdo_r <= rsp_tdo_r | (MaxLen'(td_i) << bit_cnt_r);
                tms_sh_r  <= {1'b0, tms_sh_r[MaxLen-1:1]};
                tdi_sh_r  <= {1'b0, tdi_sh_r[MaxLen-1:1]};
                bit_cnt_r <= bit_cnt_r + LenW'(1);
                if (last_bit_s) begin
                    tms_r    <= tms_r;
                    td_r     <= td_r;
                    trst_n_r <= 1'b1;
                end else begin
                    tms_r    <= tms_sh_r[0];
                    td_r     <= tdi_sh_r[0];
                    trst_n_r <= trst_n_r;
                end
            end else begin
                tms_r     <= tms_r;
                td_r      <= td_r;
                trst_n_r  <= trst_n_r;
                rsp_tdo_r <= rsp_tdo_r;
                tms_sh_r  <= tms_sh_r;
                tdi_sh_r  <= tdi_sh_r;
                len_r     <= len_r;
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    assign tck_o     = tck_r;
    assign tms_o     = tms_r;
    assign td_o      = td_r;
    assign trst_no   = trst_n_r;
    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_tdo   = rsp_tdo_r;

endmodule

// File: tb/tb_jtag_host_shifter.sv
// Scoreboard bench for jtag_host_shifter with a simple TAP shift model on the pins.
module tb_jtag_host_shifter;
    import jtag_host_pkg::*;

    localparam int HP = 2;

    typedef struct {
        logic [31:0] tdo;
        int          lat;
    } exp_t;

    logic        clk_sys_i;
    logic        rst_sys_ni;
    logic        cmd_valid;
    logic        cmd_ready;
    len_t        cmd_len;
    logic [31:0] cmd_tms;
    logic [31:0] cmd_tdi;
    logic        cmd_trst;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_tdo;
    logic        tck_o;
    logic        tms_o;
    logic        td_o;
    logic        trst_no;
    logic        td_i;

    logic [31:0] tap_shift;
    logic [31:0] tap_obs;
    exp_t        sb_q[$];
    int          checks;
    int          failures;
    int          lat;
    int          rises;
    int          hi_cyc;
    int          trst_bad;
    int          tms_zero;
    bit          to;

    jtag_host_shifter #(
        .HalfPeriod (HP),
        .MaxLen     (32)
    ) dut (
        .clk_sys_i  (clk_sys_i),
        .rst_sys_ni (rst_sys_ni),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .cmd_tms    (cmd_tms),
        .cmd_tdi    (cmd_tdi),
        .cmd_trst   (cmd_trst),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_tdo    (rsp_tdo),
        .tck_o      (tck_o),
        .tms_o      (tms_o),
        .td_o       (td_o),
        .trst_no    (trst_no),
        .td_i       (td_i)
    );

    assign td_i = tap_shift[0];

    initial clk_sys_i = 1'b0;
    always #5 clk_sys_i = ~clk_sys_i;

    task automatic issue(input int len, input logic [31:0] tms, input logic [31:0] tdi,
                         input logic trst, input logic [31:0] preload);
        exp_t e;
        int   eff;
        eff = (len > 32) ? 32 : len;
        @(negedge clk_sys_i);
        cmd_len   = len_t'(len);
        cmd_tms   = tms;
        cmd_tdi   = tdi;
        cmd_trst  = trst;
        tap_shift = preload;
        tap_obs   = 32'h0;
        cmd_valid = 1'b1;
        @(posedge clk_sys_i);
        #1;
        cmd_valid = 1'b0;
        e.tdo = (eff == 32) ? preload : (preload & ((32'd1 << eff) - 32'd1));
        e.lat = 1 + 2 * HP * eff;
        sb_q.push_back(e);
    endtask

    // Runs the TAP model each cycle until rsp_valid; lat=1 is the cycle after accept.
    task automatic wait_rsp(input logic trst_act, input int act_cycles, input int max_cyc);
        logic prev_tck;
        logic exp_trst_n;
        prev_tck = 1'b0;
        lat = 1; rises = 0; hi_cyc = 0; trst_bad = 0; tms_zero = 0; to = 1'b0;
        forever begin
            if (prev_tck && !tck_o) tap_shift = {1'b0, tap_shift[31:1]};
            if (!prev_tck && tck_o) begin
                if (rises < 32) tap_obs[rises[4:0]] = td_o;
                rises++;
            end
            if (tck_o === 1'b1) hi_cyc++;
            exp_trst_n = (lat <= act_cycles) ? ~trst_act : 1'b1;
            if (trst_no !== exp_trst_n) trst_bad++;
            if (tms_o !== 1'b1) tms_zero++;
            prev_tck = tck_o;
            if (rsp_valid === 1'b1) break;
            if (lat >= max_cyc) begin
                to = 1'b1;
                break;
            end
            @(posedge clk_sys_i);
            #1;
            lat++;
        end
    endtask

    task automatic finish_rsp();
        @(negedge clk_sys_i);
        rsp_ready = 1'b1;
        @(posedge clk_sys_i);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0; cmd_len = '0; cmd_tms = '0; cmd_tdi = '0; cmd_trst = 1'b0;
        rsp_ready = 1'b0; tap_shift = '0; tap_obs = '0;
        rst_sys_ni = 1'b0;
        repeat (3) @(posedge clk_sys_i);
        #1;
        checks++;
        if ({tck_o, tms_o, td_o, trst_no, rsp_valid} !== 5'b01010 || rsp_tdo !== 32'h0) begin
            failures++;
            $display("FAIL reset_pins: got %b tdo=%h want 01010 tdo=0",
                     {tck_o, tms_o, td_o, trst_no, rsp_valid}, rsp_tdo);
        end
        @(negedge clk_sys_i);
        rst_sys_ni = 1'b1;
        @(posedge clk_sys_i);
        #1;
        checks++;
        if ({tck_o, tms_o, td_o, trst_no, rsp_valid, cmd_ready} !== 6'b010101) begin
            failures++;
            $display("FAIL reset_release: got %b want 010101",
                     {tck_o, tms_o, td_o, trst_no, rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_tlr();
        exp_t e;
        issue(5, 32'h1F, 32'h0, 1'b0, 32'h15);
        wait_rsp(1'b0, 0, 200);
        e = sb_q.pop_front();
        checks++;
        if (to || lat != e.lat) begin
            failures++;
            $display("FAIL tlr_latency: got %0d (timeout=%0d) want %0d", lat, to, e.lat);
        end
        checks++;
        if (rises != 5 || hi_cyc != 5 * HP) begin
            failures++;
            $display("FAIL tlr_pulses: got rises=%0d high=%0d want 5 and %0d", rises, hi_cyc, 5 * HP);
        end
        checks++;
        if (tms_zero != 0 || trst_bad != 0) begin
            failures++;
            $display("FAIL tlr_tms_trst: got tms_low=%0d trst_bad=%0d want 0 and 0", tms_zero, trst_bad);
        end
        checks++;
        if (rsp_tdo !== e.tdo) begin
            failures++;
            $display("FAIL tlr_tdo: got %h want %h", rsp_tdo, e.tdo);
        end
        finish_rsp();
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL tlr_handshake: got %b want 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_dr_scan();
        exp_t e;
        issue(8, 32'h80, 32'hA5, 1'b0, 32'hFFFF_FF3C);
        wait_rsp(1'b0, 0, 200);
        e = sb_q.pop_front();
        checks++;
        if (to || lat != e.lat || rises != 8) begin
            failures++;
            $display("FAIL dr_timing: got lat=%0d rises=%0d want %0d and 8", lat, rises, e.lat);
        end
        checks++;
        if (rsp_tdo !== e.tdo || e.tdo !== 32'h3C) begin
            failures++;
            $display("FAIL dr_tdo: got %h want 0000003c", rsp_tdo);
        end
        checks++;
        if (tap_obs[7:0] !== 8'hA5) begin
            failures++;
            $display("FAIL dr_tap_tdi: got %h want a5", tap_obs[7:0]);
        end
        checks++;
        if ({tck_o, tms_o, td_o} !== 3'b011) begin
            failures++;
            $display("FAIL dr_hold_pins: got %b want 011", {tck_o, tms_o, td_o});
        end
        finish_rsp();
    endtask

    task automatic test_zero_len();
        exp_t e;
        issue(0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'hFFFF_FFFF);
        wait_rsp(1'b1, 0, 50);
        e = sb_q.pop_front();
        checks++;
        if (to || lat != 1 || lat != e.lat) begin
            failures++;
            $display("FAIL zero_latency: got %0d want 1", lat);
        end
        checks++;
        if (rsp_tdo !== e.tdo || rises != 0 || hi_cyc != 0 || trst_bad != 0) begin
            failures++;
            $display("FAIL zero_quiet: got tdo=%h rises=%0d trst_bad=%0d want 0,0,0",
                     rsp_tdo, rises, trst_bad);
        end
        checks++;
        if ({tms_o, td_o} !== 2'b11) begin
            failures++;
            $display("FAIL zero_hold_pins: got %b want 11", {tms_o, td_o});
        end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t e2;
        issue(3, 32'h0, 32'h5, 1'b0, 32'h6);
        wait_rsp(1'b0, 0, 200);
        e = sb_q.pop_front();
        checks++;
        if (to || lat != e.lat || rsp_tdo !== e.tdo) begin
            failures++;
            $display("FAIL bp_first: got lat=%0d tdo=%h want %0d %h", lat, rsp_tdo, e.lat, e.tdo);
        end
        @(negedge clk_sys_i);
        cmd_len = len_t'(4); cmd_tms = 32'h0; cmd_tdi = 32'hC; cmd_trst = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_sys_i);
            #1;
            checks++;
            if ({rsp_valid, cmd_ready, tck_o} !== 3'b100 || rsp_tdo !== e.tdo) begin
                failures++;
                $display("FAIL bp_hold: cycle %0d got v/r/tck=%b tdo=%h want 100 %h",
                         i, {rsp_valid, cmd_ready, tck_o}, rsp_tdo, e.tdo);
            end
        end
        @(negedge clk_sys_i);
        rsp_ready = 1'b1;
        tap_shift = 32'h9;
        tap_obs   = 32'h0;
        e2.tdo = 32'h9;
        e2.lat = 1 + 2 * HP * 4;
        sb_q.push_back(e2);
        @(posedge clk_sys_i);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_release: got %b want 01", {rsp_valid, cmd_ready});
        end
        @(posedge clk_sys_i);
        #1;
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_second_accept: got cmd_ready=%b want 0", cmd_ready);
        end
        wait_rsp(1'b0, 0, 200);
        e2 = sb_q.pop_front();
        checks++;
        if (to || lat != e2.lat || rsp_tdo !== e2.tdo || tap_obs[3:0] !== 4'hC) begin
            failures++;
            $display("FAIL bp_second: got lat=%0d tdo=%h tdi=%h want %0d %h c",
                     lat, rsp_tdo, tap_obs[3:0], e2.lat, e2.tdo);
        end
        finish_rsp();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic prev_tck;
        int   seen_valid;
        issue(6, 32'h0, 32'h2A, 1'b1, 32'h3F);
        sb_q.delete();
        prev_tck = 1'b0;
        rises = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_sys_i);
            #1;
            if (!prev_tck && tck_o) rises++;
            prev_tck = tck_o;
            if (rises == 4 && tck_o === 1'b1) break;
        end
        checks++;
        if (rises != 4 || tck_o !== 1'b1 || trst_no !== 1'b0 || td_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_reach: got rises=%0d tck=%b trst_n=%b td=%b want 4 1 0 1",
                     rises, tck_o, trst_no, td_o);
        end
        @(negedge clk_sys_i);
        rst_sys_ni = 1'b0;
        #1;
        checks++;
        if ({tck_o, tms_o, td_o, trst_no, rsp_valid} !== 5'b01010 || rsp_tdo !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_pins: got %b tdo=%h want 01010 tdo=0",
                     {tck_o, tms_o, td_o, trst_no, rsp_valid}, rsp_tdo);
        end
        repeat (3) @(posedge clk_sys_i);
        @(negedge clk_sys_i);
        rst_sys_ni = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_sys_i);
            #1;
            if (rsp_valid !== 1'b0) seen_valid++;
        end
        checks++;
        if (seen_valid != 0) begin
            failures++;
            $display("FAIL rst_mid_no_rsp: got %0d valid cycles want 0", seen_valid);
        end
        issue(4, 32'h0, 32'h3, 1'b0, 32'hA);
        wait_rsp(1'b0, 0, 200);
        e = sb_q.pop_front();
        checks++;
        if (to || lat != e.lat || rsp_tdo !== e.tdo || tap_obs[3:0] !== 4'h3) begin
            failures++;
            $display("FAIL rst_mid_after: got lat=%0d tdo=%h tdi=%h want %0d %h 3",
                     lat, rsp_tdo, tap_obs[3:0], e.lat, e.tdo);
        end
        finish_rsp();
    endtask

    task automatic test_clamp_trst();
        exp_t e;
        issue(40, 32'h0, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678);
        wait_rsp(1'b1, 2 * HP * 32, 400);
        e = sb_q.pop_front();
        checks++;
        if (to || lat != e.lat || rises != 32 || hi_cyc != 32 * HP) begin
            failures++;
            $display("FAIL clamp_pulses: got lat=%0d rises=%0d high=%0d want %0d 32 %0d",
                     lat, rises, hi_cyc, e.lat, 32 * HP);
        end
        checks++;
        if (trst_bad != 0) begin
            failures++;
            $display("FAIL clamp_trst: got %0d bad trst cycles want 0", trst_bad);
        end
        checks++;
        if (rsp_tdo !== e.tdo || tap_obs !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL clamp_data: got tdo=%h tdi=%h want %h deadbeef", rsp_tdo, tap_obs, e.tdo);
        end
        finish_rsp();
        checks++;
        if ({trst_no, tck_o} !== 2'b10) begin
            failures++;
            $display("FAIL clamp_idle: got trst_n/tck=%b want 10", {trst_no, tck_o});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_tlr();
        test_dr_scan();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        test_clamp_trst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
